// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 24;

  localparam int unsigned PORT0 = 0;
  localparam int unsigned PORT1 = 1;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, read-return and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic          req0, we0, lock0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          req1, we1, lock1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          cpu_stall;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, lock0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, cpu_stall, rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, we0, addr0, wdata0, lock0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, cpu_stall, rdata,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/dmem_arbiter_rr_grant2.sv
// Combinational two-way round-robin grant selector with bounded owner lock.
module dmem_arbiter_rr_grant2
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CW        = $clog2(MAX_BURST) + 1
) (
  input  logic [1:0]    req,
  input  logic          owner_lock,
  input  owner_t        owner,
  input  logic          last,
  input  logic [CW-1:0] burst_cnt,
  output logic [1:0]    gnt
);

  logic hold_owner;

  // Owner keeps the memory under contention only while its lock is up and the burst budget remains.
  assign hold_owner = (owner != OWN_IDLE) && owner_lock && (burst_cnt < CW'(MAX_BURST));

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (hold_owner) gnt = (owner == OWN1) ? 2'b10 : 2'b01;
        else            gnt = last ? 2'b01 : 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the CPU port (0) and the debug/loader port (1).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  owner_t        owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          we_c;
  logic          owner_lock;
  logic [1:0]    sel_gnt, gnt;

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == CW'(MAX_BURST)) ? c : c + CW'(1);
  endfunction

  // Only the current owner's lock matters; a non-owner lock is ignored.
  always_comb begin
    owner_lock = 1'b0;
    unique case (owner_q)
      OWN0:    owner_lock = bus.lock0;
      OWN1:    owner_lock = bus.lock1;
      default: owner_lock = 1'b0;
    endcase
  end

  dmem_arbiter_rr_grant2 #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_sel (
    .req        ({bus.req1, bus.req0}),
    .owner_lock (owner_lock),
    .owner      (owner_q),
    .last       (last_q),
    .burst_cnt  (cnt_q),
    .gnt        (sel_gnt)
  );

  // No access may happen while reset is held, including a write in the reset cycle.
  assign gnt = rst ? sel_gnt : 2'b00;

  always_comb begin
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    we_c      = 1'b0;
    if (gnt[PORT1]) begin
      addr_d    = bus.addr1;
      wdata_d   = bus.wdata1;
      we_c      = bus.we1;
      rvalid1_d = ~bus.we1;
      owner_d   = OWN1;
      last_d    = 1'b1;
      cnt_d     = (owner_q == OWN1) ? cnt_inc(cnt_q) : CW'(1);
    end else if (gnt[PORT0]) begin
      addr_d    = bus.addr0;
      wdata_d   = bus.wdata0;
      we_c      = bus.we0;
      rvalid0_d = ~bus.we0;
      owner_d   = OWN0;
      last_d    = 1'b0;
      cnt_d     = (owner_q == OWN0) ? cnt_inc(cnt_q) : CW'(1);
    end else begin
      owner_d = OWN_IDLE;
      cnt_d   = '0;
    end
    if (rvalid0_d || rvalid1_d) rdata_d = bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Memory address/data follow the granted port and otherwise hold the last granted values.
  assign bus.mem_addr  = addr_d;
  assign bus.mem_wdata = wdata_d;
  assign bus.mem_we    = we_c;
  assign bus.gnt0      = gnt[PORT0];
  assign bus.gnt1      = gnt[PORT1];
  assign bus.cpu_stall = bus.req0 & ~gnt[PORT0];
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table followed by randomized traffic against a reference model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bit [DW-1:0] mem [0:(1<<AW)-1];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    logic          rst;
    logic          r0, w0, l0, r1, w1, l1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          g0, g1, mwe, st, rv0, rv1, chk;
    logic [DW-1:0] rd;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int rs, int r0, int w0, int a0, int d0, int l0,
                              int r1, int w1, int a1, int d1, int l1,
                              int g0, int g1, int mwe, int st, int rv0, int rv1,
                              int ck, int rd);
    vec_t v;
    v.rst = rs[0]; v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = AW'(a0); v.d0 = DW'(d0); v.l0 = l0[0];
    v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = AW'(a1); v.d1 = DW'(d1); v.l1 = l1[0];
    v.g0 = g0[0]; v.g1 = g1[0]; v.mwe = mwe[0]; v.st = st[0];
    v.rv0 = rv0[0]; v.rv1 = rv1[0]; v.chk = ck[0]; v.rd = DW'(rd);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst;
    bus.req0 = v.r0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0; bus.lock0 = v.l0;
    bus.req1 = v.r1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1; bus.lock1 = v.l1;
  endtask

  // Reference model state: owner (-1 idle), last granted port, burst count, read return.
  int          m_owner, m_last, m_cnt;
  bit          m_rv0, m_rv1;
  bit [DW-1:0] m_rdata;
  bit [AW-1:0] m_addr;
  bit [DW-1:0] ref_mem [16];

  bit          p_req [2];
  bit          p_we  [2];
  bit          p_lk  [2];
  bit [3:0]    p_idx [2];
  bit [DW-1:0] p_dat [2];

  function automatic int pick();
    if (!p_req[0] && !p_req[1]) return -1;
    if (!p_req[1]) return 0;
    if (!p_req[0]) return 1;
    if (m_owner >= 0 && p_lk[m_owner] && m_cnt < int'(MB)) return m_owner;
    return 1 - m_last;
  endfunction

  vec_t tbl [$];

  initial begin
    int p;
    bit [AW-1:0] exp_addr;
    vec_t v;

    // rst, port0 {req,we,addr,data,lock}, port1 {...}, expected {g0,g1,mwe,stall,rv0,rv1,chk_rdata,rdata}
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1,0,0,0,0,            1,0,0,0,0,            0,0,0,1, 0,0,1,0));
    tbl.push_back(mk(1, 1,0,'h20,0,0,           1,0,'h30,0,0,         1,0,0,0, 0,0,1,0));
    tbl.push_back(mk(1, 1,1,'h10,'hABCDEF,0,    0,0,0,0,0,            1,0,1,0, 1,0,1,0));
    tbl.push_back(mk(1, 1,0,'h10,0,0,           0,0,0,0,0,            1,0,0,0, 0,0,1,0));
    tbl.push_back(mk(1, 0,0,0,0,0,              0,0,0,0,0,            0,0,0,0, 1,0,1,'hABCDEF));
    tbl.push_back(mk(1, 0,0,0,0,0,              1,1,'h40,'h123456,0,  0,1,1,0, 0,0,0,0));
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(1, 1,0,'h10,0,0, 1,0,'h40,0,0, 1,0,0,0, 0,(i>0)?1:0,1,(i>0)?'h123456:'hABCDEF));
      tbl.push_back(mk(1, 1,0,'h10,0,0, 1,0,'h40,0,0, 0,1,0,1, 1,0,1,'hABCDEF));
    end
    tbl.push_back(mk(1, 0,0,0,0,0,              0,0,0,0,0,            0,0,0,0, 0,1,1,'h123456));
    tbl.push_back(mk(1, 0,0,0,0,0,              1,0,'h40,0,1,         0,1,0,0, 0,0,1,'h123456));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1,0,'h10,0,0,         1,0,'h40,0,1,         0,1,0,1, 0,1,1,'h123456));
    tbl.push_back(mk(1, 1,0,'h10,0,0,           1,0,'h40,0,1,         1,0,0,0, 0,1,1,'h123456));
    tbl.push_back(mk(1, 1,0,'h10,0,0,           1,0,'h40,0,1,         0,1,0,1, 1,0,1,'hABCDEF));
    tbl.push_back(mk(1, 1,0,'h10,0,1,           0,0,0,0,0,            1,0,0,0, 0,1,1,'h123456));
    tbl.push_back(mk(1, 1,0,'h10,0,1,           1,1,'h50,'h777777,1,  1,0,0,0, 1,0,1,'hABCDEF));
    tbl.push_back(mk(1, 1,0,'h50,0,0,           0,0,0,0,0,            1,0,0,0, 1,0,1,'hABCDEF));
    tbl.push_back(mk(1, 0,0,0,0,0,              0,0,0,0,0,            0,0,0,0, 1,0,1,0));
    tbl.push_back(mk(1, 1,0,'h40,0,0,           0,0,0,0,0,            1,0,0,0, 0,0,1,0));
    tbl.push_back(mk(0, 1,1,'h60,'h555555,0,    1,0,'h40,0,0,         0,0,0,1, 0,0,1,0));
    tbl.push_back(mk(1, 1,0,'h10,0,0,           1,0,'h40,0,0,         1,0,0,0, 0,0,1,0));
    tbl.push_back(mk(1, 1,0,'h60,0,0,           0,0,0,0,0,            1,0,0,0, 1,0,1,'hABCDEF));
    tbl.push_back(mk(1, 0,0,0,0,0,              0,0,0,0,0,            0,0,0,0, 1,0,1,0));

    drive(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d gnt0", i),   32'(bus.gnt0),      32'(tbl[i].g0));
      chk($sformatf("v%0d gnt1", i),   32'(bus.gnt1),      32'(tbl[i].g1));
      chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we),    32'(tbl[i].mwe));
      chk($sformatf("v%0d stall", i),  32'(bus.cpu_stall), 32'(tbl[i].st));
      chk($sformatf("v%0d rvalid0", i), 32'(bus.rvalid0),  32'(tbl[i].rv0));
      chk($sformatf("v%0d rvalid1", i), 32'(bus.rvalid1),  32'(tbl[i].rv1));
      if (tbl[i].chk) chk($sformatf("v%0d rdata", i), 32'(bus.rdata), 32'(tbl[i].rd));
    end

    // Randomized traffic on a fresh address window, after a reset pulse.
    @(negedge clk);
    v = mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    drive(v);
    m_owner = -1; m_last = 1; m_cnt = 0;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0; m_addr = '0;
    for (int k = 0; k < 2; k++) p_req[k] = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (!p_req[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            p_req[k] = 1'b1;
            p_we[k]  = 1'($urandom_range(0, 1));
            p_idx[k] = 4'($urandom_range(0, 15));
            p_dat[k] = DW'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          p_req[k] = 1'b0;
        end
        p_lk[k] = 1'($urandom_range(0, 1));
      end
      bus.req0 = p_req[0]; bus.we0 = p_we[0]; bus.addr0 = AW'('h100) + AW'(p_idx[0]);
      bus.wdata0 = p_dat[0]; bus.lock0 = p_lk[0];
      bus.req1 = p_req[1]; bus.we1 = p_we[1]; bus.addr1 = AW'('h100) + AW'(p_idx[1]);
      bus.wdata1 = p_dat[1]; bus.lock1 = p_lk[1];
      #1;
      p = pick();
      exp_addr = (p >= 0) ? AW'('h100) + AW'(p_idx[p]) : m_addr;
      chk($sformatf("r%0d gnt0", i),    32'(bus.gnt0),      32'(p == 0));
      chk($sformatf("r%0d gnt1", i),    32'(bus.gnt1),      32'(p == 1));
      chk($sformatf("r%0d mem_we", i),  32'(bus.mem_we),    32'((p >= 0) && p_we[p]));
      chk($sformatf("r%0d stall", i),   32'(bus.cpu_stall), 32'(p_req[0] && (p != 0)));
      chk($sformatf("r%0d mem_addr", i), 32'(bus.mem_addr), 32'(exp_addr));
      chk($sformatf("r%0d rvalid0", i), 32'(bus.rvalid0),   32'(m_rv0));
      chk($sformatf("r%0d rvalid1", i), 32'(bus.rvalid1),   32'(m_rv1));
      chk($sformatf("r%0d rdata", i),   32'(bus.rdata),     32'(m_rdata));
      m_rv0 = 1'b0;
      m_rv1 = 1'b0;
      if (p < 0) begin
        m_owner = -1;
        m_cnt   = 0;
      end else begin
        if (p_we[p]) ref_mem[p_idx[p]] = p_dat[p];
        else begin
          m_rdata = ref_mem[p_idx[p]];
          if (p == 0) m_rv0 = 1'b1; else m_rv1 = 1'b1;
        end
        m_cnt   = (p == m_owner) ? ((m_cnt < int'(MB)) ? m_cnt + 1 : m_cnt) : 1;
        m_owner = p;
        m_last  = p;
        m_addr  = exp_addr;
        p_req[p] = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
